multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU. It sequences a shared datapath (single ALU, single memory port, GRF, PC/IR registers) through FETCH/DECODE/EXEC/MEM/WB states. It drives per-cycle write enables, mux selects and ALU operation from the latched instruction, replacing the single-cycle decoder. Supported set: addu, subu, ori, lw, sw, beq, lui, j, jal, jr, nop; any other encoding retires as nop.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_instr_class.sv | 39 +++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller and future decoders.
// Pure declarations: no logic, no latency. No flow control.
// Holds state encoding, ALU/select codes, opcode/funct constants and the class flag struct.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [1:0] NPC_PC4  = 2'd0;
    localparam logic [1:0] NPC_BR   = 2'd1;
    localparam logic [1:0] NPC_JUMP = 2'd2;
    localparam logic [1:0] NPC_RS   = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_DM  = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef struct packed {
        logic alu_r;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic nop;
    } instr_class_t;

endpackage

// File: rtl/mc_instr_class.sv
// Opcode/funct decode of a 32-bit instruction word into one-hot class flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module mc_instr_class
    import mc_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       is_rtype;
    logic       unused_fields;

    assign op       = instr[31:26];
    assign funct    = instr[5:0];
    assign is_rtype = (op == OP_RTYPE);

    // Register and immediate fields do not affect the class.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls       = '0;
        cls.alu_r = is_rtype && ((funct == FN_ADDU) || (funct == FN_SUBU));
        cls.jr    = is_rtype && (funct == FN_JR);
        cls.ori   = (op == OP_ORI);
        cls.lui   = (op == OP_LUI);
        cls.lw    = (op == OP_LW);
        cls.sw    = (op == OP_SW);
        cls.beq   = (op == OP_BEQ);
        cls.j     = (op == OP_J);
        cls.jal   = (op == OP_JAL);
        // Anything unrecognised, including the all-zero word, retires as nop.
        cls.nop   = ~(cls.alu_r | cls.jr | cls.ori | cls.lui | cls.lw |
                      cls.sw | cls.beq | cls.j | cls.jal);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller; optional MC_MEM_WAIT_EN adds the mem_ready port.
// Latency: outputs combinational from state and instr; CPI 2 (j/jr/nop) to 5 (lw).
// Backpressure: with MC_MEM_WAIT_EN, MEM holds until mem_ready; otherwise MEM is always one cycle.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             equal,
`ifdef MC_MEM_WAIT_EN
    input  logic             mem_ready,
`endif
    output logic             PC_WE,
    output logic             IR_WE,
    output logic [1:0]       npc_sel,
    output logic             GRF_WE,
    output logic [1:0]       sel_rt_rd_31,
    output logic [1:0]       sel_alu_dm_pc4,
    output logic             sel_zero_sign,
    output logic             sel_imm32_rt,
    output logic [2:0]       ALUOp,
    output logic             DM_RE,
    output logic             DM_WE,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    state_t       cur_state;
    state_t       next_state;
    instr_class_t cls;
    logic         mem_go;
    logic         hold_sel;

    mc_instr_class u_class (
        .instr (instr),
        .cls   (cls)
    );

`ifdef MC_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= ST_FETCH;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (instr_done) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        PC_WE      = 1'b0;
        IR_WE      = 1'b0;
        npc_sel    = NPC_PC4;
        GRF_WE     = 1'b0;
        DM_RE      = 1'b0;
        DM_WE      = 1'b0;
        instr_done = 1'b0;

        case (cur_state)
            ST_FETCH: begin
                IR_WE      = 1'b1;
                PC_WE      = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls.j || cls.jr) begin
                    PC_WE      = 1'b1;
                    npc_sel    = cls.jr ? NPC_RS : NPC_JUMP;
                    instr_done = 1'b1;
                    next_state = ST_FETCH;
                end else if (cls.jal) begin
                    // PC+4 latch already holds the link value, so the PC can be
                    // redirected now; jal then idles through EXEC to keep CPI 4.
                    PC_WE      = 1'b1;
                    npc_sel    = NPC_JUMP;
                    next_state = ST_EXEC;
                end else if (cls.nop) begin
                    instr_done = 1'b1;
                    next_state = ST_FETCH;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cls.beq) begin
                    PC_WE      = equal;
                    npc_sel    = NPC_BR;
                    instr_done = 1'b1;
                    next_state = ST_FETCH;
                end else if (cls.lw || cls.sw) begin
                    next_state = ST_MEM;
                end else begin
                    next_state = ST_WB;
                end
            end
            ST_MEM: begin
                if (cls.lw) begin
                    DM_RE = 1'b1;
                    if (mem_go) begin
                        next_state = ST_WB;
                    end
                end else begin
                    DM_WE = 1'b1;
                    if (mem_go) begin
                        instr_done = 1'b1;
                        next_state = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                GRF_WE     = 1'b1;
                instr_done = 1'b1;
                next_state = ST_FETCH;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase

        // Reset kills every side effect, including one mid-instruction.
        if (reset) begin
            PC_WE      = 1'b0;
            IR_WE      = 1'b0;
            GRF_WE     = 1'b0;
            DM_RE      = 1'b0;
            DM_WE      = 1'b0;
            instr_done = 1'b0;
        end
    end

    // Datapath selects are set from EXEC onward and held to the last cycle.
    assign hold_sel = (cur_state == ST_EXEC) || (cur_state == ST_MEM) || (cur_state == ST_WB);

    always_comb begin
        sel_zero_sign  = 1'b0;
        sel_imm32_rt   = 1'b0;
        ALUOp          = ALU_ADD;
        sel_rt_rd_31   = DST_RT;
        sel_alu_dm_pc4 = WB_ALU;
        if (hold_sel) begin
            sel_zero_sign = cls.lw || cls.sw;
            sel_imm32_rt  = cls.alu_r || cls.beq;
            if (cls.beq || (cls.alu_r && (instr[5:0] == FN_SUBU))) begin
                ALUOp = ALU_SUB;
            end else if (cls.ori) begin
                ALUOp = ALU_OR;
            end else if (cls.lui) begin
                ALUOp = ALU_LUI;
            end
            if (cls.alu_r) begin
                sel_rt_rd_31 = DST_RD;
            end else if (cls.jal) begin
                sel_rt_rd_31 = DST_RA;
            end
            if (cls.lw) begin
                sel_alu_dm_pc4 = WB_DM;
            end else if (cls.jal) begin
                sel_alu_dm_pc4 = WB_PC4;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: hand-written vector table, reset corner cases, random vs reference model.
// A narrow retired counter is used so wrap-around is exercised.
module tb_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr;
    logic          equal;
    logic          mem_ready;
    logic          PC_WE, IR_WE, GRF_WE, DM_RE, DM_WE, instr_done;
    logic          sel_zero_sign, sel_imm32_rt;
    logic [1:0]    npc_sel, sel_rt_rd_31, sel_alu_dm_pc4;
    logic [2:0]    ALUOp, state;
    logic [CW-1:0] retired;

    int tests  = 0;
    int failed = 0;
    int ret_model = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .instr          (instr),
        .equal          (equal),
`ifdef MC_MEM_WAIT_EN
        .mem_ready      (mem_ready),
`endif
        .PC_WE          (PC_WE),
        .IR_WE          (IR_WE),
        .npc_sel        (npc_sel),
        .GRF_WE         (GRF_WE),
        .sel_rt_rd_31   (sel_rt_rd_31),
        .sel_alu_dm_pc4 (sel_alu_dm_pc4),
        .sel_zero_sign  (sel_zero_sign),
        .sel_imm32_rt   (sel_imm32_rt),
        .ALUOp          (ALUOp),
        .DM_RE          (DM_RE),
        .DM_WE          (DM_WE),
        .state          (state),
        .instr_done     (instr_done),
        .retired        (retired)
    );

    typedef struct {
        int          cycles;
        logic [31:0] seq;
        int          pcwe;
        int          npc;
        int          grf;
        int          dest;
        int          wbsel;
        int          dmre;
        int          dmwe;
        int          chk_alu;
        int          alu;
        int          imm;
        int          zs;
    } exp_t;

    typedef struct {
        int          cycles;
        logic [31:0] seq;
        int          pcwe;
        int          npc;
        int          grf;
        int          dest;
        int          wbsel;
        int          dmre;
        int          dmwe;
        int          ir_mask;
        int          alu;
        int          imm;
        int          zs;
        int          alu_stable;
        int          ret;
    } obs_t;

    typedef struct {
        logic [31:0] w;
        logic        eq;
        exp_t        e;
    } vec_t;

    function automatic void check(input string name, input int idx,
                                  input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h", name, idx, act, expv);
        end
    endfunction

    function automatic logic [31:0] sq(input int n, input int a, input int b,
                                       input int c, input int d, input int f);
        int s[5];
        logic [31:0] r;
        s = '{a, b, c, d, f};
        r = '0;
        for (int k = 0; k < n; k++) r[3*k +: 3] = 3'(s[k]);
        return r;
    endfunction

    function automatic vec_t vec(input logic [31:0] w, input logic eq, input int cyc,
                                 input logic [31:0] s, input int pcwe, input int npc,
                                 input int grf, input int dest, input int wbsel,
                                 input int dmre, input int dmwe, input int chk,
                                 input int alu, input int imm, input int zs);
        vec_t v;
        v.w = w;
        v.eq = eq;
        v.e = '{cyc, s, pcwe, npc, grf, dest, wbsel, dmre, dmwe, chk, alu, imm, zs};
        return v;
    endfunction

    // Reference: per-class state path and side effects, straight from the instruction rules.
    function automatic exp_t model(input logic [31:0] w, input logic eq, input int hold);
        exp_t e;
        int st[$];
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        e = '{default: 0};
        e.pcwe = 1;
        if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23)) begin
            st = '{0, 1, 2, 4}; e.grf = 1; e.dest = 1; e.chk_alu = 1;
            e.alu = (fn == 6'h23) ? 1 : 0; e.imm = 1;
        end else if (op == 6'h00 && fn == 6'h08) begin
            st = '{0, 1}; e.pcwe = 2; e.npc = 3;
        end else if (op == 6'h0D || op == 6'h0F) begin
            st = '{0, 1, 2, 4}; e.grf = 1; e.chk_alu = 1;
            e.alu = (op == 6'h0D) ? 2 : 3;
        end else if (op == 6'h23 || op == 6'h2B) begin
            st = '{0, 1, 2};
            for (int k = 0; k <= hold; k++) st.push_back(3);
            if (op == 6'h23) begin
                st.push_back(4); e.grf = 1; e.wbsel = 1; e.dmre = hold + 1;
            end else begin
                e.dmwe = hold + 1;
            end
            e.chk_alu = 1; e.zs = 1;
        end else if (op == 6'h04) begin
            st = '{0, 1, 2}; e.chk_alu = 1; e.alu = 1; e.imm = 1;
            if (eq) begin e.pcwe = 2; e.npc = 1; end
        end else if (op == 6'h02) begin
            st = '{0, 1}; e.pcwe = 2; e.npc = 2;
        end else if (op == 6'h03) begin
            st = '{0, 1, 2, 4}; e.pcwe = 2; e.npc = 2; e.grf = 1; e.dest = 2; e.wbsel = 2;
        end else begin
            st = '{0, 1};
        end
        e.cycles = st.size();
        e.seq = '0;
        for (int k = 0; k < st.size() && k < 10; k++) e.seq[3*k +: 3] = 3'(st[k]);
        return e;
    endfunction

    // Caller is 1 time unit after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] w, input logic eq, input int hold,
                             output obs_t o);
        int   hold_left;
        int   seen_exec;
        logic done_now;
        o = '{default: 0};
        o.alu_stable = 1;
        seen_exec = 0;
        hold_left = hold;
        instr = w;
        equal = eq;
        for (int k = 0; k < 20; k++) begin
            mem_ready = !(hold_left > 0 && state == 3'd3);
            if (!mem_ready) hold_left--;
            #2;
            if (k < 10) o.seq[3*k +: 3] = state;
            if (PC_WE) begin o.pcwe++; o.npc = int'(npc_sel); end
            if (IR_WE) o.ir_mask |= (1 << k);
            if (GRF_WE) begin o.grf++; o.dest = int'(sel_rt_rd_31); o.wbsel = int'(sel_alu_dm_pc4); end
            if (DM_RE) o.dmre++;
            if (DM_WE) o.dmwe++;
            if (state >= 3'd2) begin
                if (seen_exec == 0) begin
                    seen_exec = 1;
                    o.alu = int'(ALUOp); o.imm = int'(sel_imm32_rt); o.zs = int'(sel_zero_sign);
                end else if (o.alu != int'(ALUOp) || o.imm != int'(sel_imm32_rt) ||
                             o.zs != int'(sel_zero_sign)) begin
                    o.alu_stable = 0;
                end
            end
            o.cycles = k + 1;
            done_now = instr_done;
            @(posedge clk); #1;
            if (done_now) break;
            if (k == 19) o.cycles = 99;
        end
        mem_ready = 1'b1;
        o.ret = int'(retired);
    endtask

    task automatic compare(input int idx, input obs_t o, input exp_t e);
        ret_model = (ret_model + 1) % (1 << CW);
        check("cycles", idx, o.cycles, e.cycles);
        check("state_seq", idx, o.seq, e.seq);
        check("pc_we_count", idx, o.pcwe, e.pcwe);
        check("npc_sel", idx, o.npc, e.npc);
        check("grf_we_count", idx, o.grf, e.grf);
        check("dest_sel", idx, o.dest, e.dest);
        check("wb_sel", idx, o.wbsel, e.wbsel);
        check("dm_re_count", idx, o.dmre, e.dmre);
        check("dm_we_count", idx, o.dmwe, e.dmwe);
        check("ir_we_fetch_only", idx, o.ir_mask, 1);
        if (e.chk_alu != 0) begin
            check("aluop", idx, o.alu, e.alu);
            check("sel_imm32_rt", idx, o.imm, e.imm);
            check("sel_zero_sign", idx, o.zs, e.zs);
            check("alu_hold", idx, o.alu_stable, 1);
        end
        check("retired", idx, o.ret, ret_model);
    endtask

    initial begin
        vec_t vt[13];
        obs_t o;
        logic [31:0] w;
        int hold;

        vt[0]  = vec(32'h00221821, 1'b0, 4, sq(4,0,1,2,4,0), 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0);
        vt[1]  = vec(32'h8C040008, 1'b0, 5, sq(5,0,1,2,3,4), 1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1);
        vt[2]  = vec(32'h10220003, 1'b1, 3, sq(3,0,1,2,0,0), 2, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        vt[3]  = vec(32'h10220003, 1'b0, 3, sq(3,0,1,2,0,0), 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        vt[4]  = vec(32'h0C000C00, 1'b0, 4, sq(4,0,1,2,4,0), 2, 2, 1, 2, 2, 0, 0, 0, 0, 0, 0);
        vt[5]  = vec(32'h03E00008, 1'b0, 2, sq(2,0,1,0,0,0), 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[6]  = vec(32'hAC040004, 1'b0, 4, sq(4,0,1,2,3,0), 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        vt[7]  = vec(32'h00221823, 1'b0, 4, sq(4,0,1,2,4,0), 1, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0);
        vt[8]  = vec(32'h342100FF, 1'b0, 4, sq(4,0,1,2,4,0), 1, 0, 1, 0, 0, 0, 0, 1, 2, 0, 0);
        vt[9]  = vec(32'h3C011234, 1'b0, 4, sq(4,0,1,2,4,0), 1, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0);
        vt[10] = vec(32'h08000010, 1'b0, 2, sq(2,0,1,0,0,0), 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[11] = vec(32'h00000000, 1'b0, 2, sq(2,0,1,0,0,0), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[12] = vec(32'hFC000000, 1'b0, 2, sq(2,0,1,0,0,0), 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        reset = 1'b1;
        instr = 32'h00221821;
        equal = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #3;
            check("reset_strobes", i,
                  {26'd0, PC_WE, IR_WE, GRF_WE, DM_WE, DM_RE, instr_done}, 32'd0);
            check("reset_state", i, {29'd0, state}, 32'd0);
            check("reset_retired", i, 32'(retired), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        ret_model = 0;

        for (int i = 0; i < 13; i++) begin
            run_instr(vt[i].w, vt[i].eq, 0, o);
            compare(i, o, vt[i].e);
        end

        // Reset landing in the MEM cycle of a store.
        instr = 32'hAC040004;
        equal = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("sw_mem_state", 100, {29'd0, state}, 32'd3);
        check("sw_mem_dm_we", 100, {31'd0, DM_WE}, 32'd1);
        reset = 1'b1;
        #2;
        check("abort_dm_we", 100, {31'd0, DM_WE}, 32'd0);
        check("abort_done", 100, {31'd0, instr_done}, 32'd0);
        @(posedge clk); #1;
        check("abort_state", 100, {29'd0, state}, 32'd0);
        check("abort_retired", 100, 32'(retired), 32'd0);
        reset = 1'b0;
        ret_model = 0;
        run_instr(32'h00221821, 1'b0, 0, o);
        compare(101, o, model(32'h00221821, 1'b0, 0));

`ifdef MC_MEM_WAIT_EN
        run_instr(32'h8C040008, 1'b0, 4, o);
        compare(200, o, model(32'h8C040008, 1'b0, 4));
        check("lw_wait_cpi", 200, o.cycles, 9);
        run_instr(32'hAC040004, 1'b0, 2, o);
        compare(201, o, model(32'hAC040004, 1'b0, 2));
`endif

        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            case ($urandom_range(0, 11))
                0:  begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
                1:  begin w[31:26] = 6'h00; w[5:0] = 6'h23; end
                2:  begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
                3:  w[31:26] = 6'h0D;
                4:  w[31:26] = 6'h0F;
                5:  w[31:26] = 6'h23;
                6:  w[31:26] = 6'h2B;
                7:  w[31:26] = 6'h04;
                8:  w[31:26] = 6'h02;
                9:  w[31:26] = 6'h03;
                10: w = 32'h0;
                default: ;
            endcase
            hold = 0;
`ifdef MC_MEM_WAIT_EN
            hold = int'($urandom_range(0, 3));
`endif
            run_instr(w, 1'($urandom_range(0, 1)), hold, o);
            compare(1000 + i, o, model(w, equal, hold));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
